// File: rtl/grid_color_writer_pkg.sv
// grid_color_writer_pkg
//   Definitions shared by the grid colour writer and the VGA reader of the
//   same frame buffer: buffer geometry, colour word layout, writer FSM state
//   encoding, colour constants and the row/col -> buffer address mapping.
package grid_color_writer_pkg;

   // 4x4 grid -> 16 cells -> 4 address bits; RGB 1-1-1 colour word
   localparam int GCW_AW = 4;
   localparam int GCW_DW = 3;

   // Colour constants (bit2 R, bit1 G, bit0 B)
   localparam logic [GCW_DW-1:0] BLACK = 3'b000;
   localparam logic [GCW_DW-1:0] RED   = 3'b100;
   localparam logic [GCW_DW-1:0] GREEN = 3'b010;
   localparam logic [GCW_DW-1:0] BLUE  = 3'b001;

   // Writer state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PAINT = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   // Button slots in the debouncer bank
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_PAINT = 4;
   localparam int BTN_CLEAR = 5;
   localparam int BTN_N     = 6;

   // Buffer address of a cell: (3-col)*4 + (3-row). For a 2-bit field,
   // 3-x is just the bitwise complement, so the address is {~col, ~row}.
   function automatic logic [GCW_AW-1:0] cell_addr(input logic [1:0] row,
                                                   input logic [1:0] col);
      return {~col, ~row};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   One raw push-button to a single-cycle rising-edge pulse.
//   2-flop synchroniser, then a counter that only adopts a new stable level
//   after DB_CYCLES consecutive synchronised samples that differ from the
//   current stable level. A pulse is emitted in the cycle the stable level
//   goes 0 -> 1, so a press yields one pulse regardless of hold time.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     btn_i     : raw asynchronous button, active-high
//     rise_o    : one-cycle pulse on the debounced rising edge
module btn_debounce #(
   parameter int DB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);

   localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

   logic [1:0]    sync_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;
   logic          rise_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         rise_q <= 1'b0;
         // Any sample equal to the stable level restarts the count
         if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
               stable_q <= sync_q[1];
               cnt_q    <= '0;
               rise_q   <= sync_q[1];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/grid_color_writer.sv
// grid_color_writer
//   Button-driven painter for a 4x4 grid frame buffer. Six debounced buttons
//   move a cursor (with wrap-around), paint the selected colour at the
//   cursor, or sweep colour 0 over every cell. Outputs drive the write port
//   of the shared dual-port buffer RAM directly.
//   Ports:
//     clk, rst                 : 25 MHz clock, synchronous active-high reset
//     btn_up/down/left/right   : raw cursor-move buttons
//     btn_paint                : raw paint request
//     btn_clear                : raw clear-all request
//     color_sel [DW]           : colour written by a paint
//     wr_addr [AW], wr_data [DW], wr_en : buffer write port
//     cursor [AW]              : buffer address of the cell under the cursor
//     busy                     : clear sweep in progress
module grid_color_writer
   import grid_color_writer_pkg::*;
#(
   parameter int AW        = GCW_AW,
   parameter int DW        = GCW_DW,
   parameter int DB_CYCLES = 250000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_paint,
   input  logic          btn_clear,
   input  logic [DW-1:0] color_sel,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          wr_en,
   output logic [AW-1:0] cursor,
   output logic          busy
);

   logic [BTN_N-1:0] raw;
   logic [BTN_N-1:0] rise;

   assign raw = {btn_clear, btn_paint, btn_right, btn_left, btn_down, btn_up};

   for (genvar g = 0; g < BTN_N; g++) begin : g_db
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk    (clk),
         .rst    (rst),
         .btn_i  (raw[g]),
         .rise_o (rise[g])
      );
   end

   state_e        state_q, state_d;
   logic [1:0]    row_q, row_d, col_q, col_d;
   logic [AW-1:0] clr_q, clr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          wr_en_q, wr_en_d;
   logic          move_en;
   logic [AW-1:0] cursor_w;

   assign cursor_w = AW'(cell_addr(row_q, col_q));

   // State, cursor and write-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_q     <= 2'd0;
         col_q     <= 2'd0;
         clr_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         clr_q     <= clr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
      end
   end

   // Next state: clear beats paint beats moves; in CLEAR every edge is dropped
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      move_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise[BTN_CLEAR]) begin
               state_d = ST_CLEAR;
               clr_d   = '0;
            end else if (rise[BTN_PAINT]) begin
               state_d = ST_PAINT;
            end else begin
               move_en = 1'b1;
            end
         end
         ST_PAINT: begin
            // Moves landing in the write cycle still apply, after the write
            state_d = ST_IDLE;
            move_en = 1'b1;
         end
         ST_CLEAR: begin
            if (clr_q == {AW{1'b1}}) state_d = ST_IDLE;
            else                     clr_d   = clr_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Opposing moves cancel; moves on both axes all apply
      row_d = row_q;
      col_d = col_q;
      if (move_en) begin
         row_d = row_q - {1'b0, rise[BTN_UP]}   + {1'b0, rise[BTN_DOWN]};
         col_d = col_q - {1'b0, rise[BTN_LEFT]} + {1'b0, rise[BTN_RIGHT]};
      end
   end

   // Write port is registered from the next state so PAINT/CLEAR cycles
   // carry wr_en, while address/data hold their last value otherwise.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_d)
         ST_PAINT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_w;
            wr_data_d = color_sel;
         end
         ST_CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_d;
            wr_data_d = DW'(BLACK);
         end
         default: ;
      endcase
   end

   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_en   = wr_en_q;
   assign cursor  = cursor_w;
   assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_grid_color_writer.sv
module tb_grid_color_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_paint = 1'b0, btn_clear = 1'b0;
   logic [2:0] color_sel = 3'b000;
   logic [3:0] wr_addr;
   logic [2:0] wr_data;
   logic       wr_en;
   logic [3:0] cursor;
   logic       busy;

   grid_color_writer #(.AW(4), .DW(3), .DB_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_paint (btn_paint),
      .btn_clear (btn_clear),
      .color_sel (color_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .cursor    (cursor),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Write / busy monitor, sampled on the falling edge
   int         wr_cnt = 0;
   int         busy_cnt = 0;
   logic [3:0] addr_log [512];
   logic [2:0] data_log [512];

   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_cnt < 512) begin
            addr_log[wr_cnt] <= wr_addr;
            data_log[wr_cnt] <= wr_data;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // mask bits: 0 up, 1 down, 2 left, 3 right, 4 paint, 5 clear
   task automatic set_btns(input logic [5:0] m);
      {btn_clear, btn_paint, btn_right, btn_left, btn_down, btn_up} = m;
   endtask

   task automatic press(input logic [5:0] m, input int hold);
      @(posedge clk); #1;
      set_btns(m);
      repeat (hold) @(posedge clk);
      #1;
      set_btns(6'b0);
      repeat (16) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0] mask;
      logic [2:0] color;
      int         exp_wr;
      int         exp_addr;
      int         exp_data;
      int         exp_cur;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int w0, b0, w1, bad;
      bit found;

      tbl[0]  = '{6'b010000, 3'b100, 1, 15, 4, 15}; // paint at reset cursor
      tbl[1]  = '{6'b000100, 3'b000, 0,  0, 0,  3}; // left: col 0 -> 3
      tbl[2]  = '{6'b000001, 3'b000, 0,  0, 0,  0}; // up: row 0 -> 3
      tbl[3]  = '{6'b010000, 3'b010, 1,  0, 2,  0}; // paint bottom-right
      tbl[4]  = '{6'b001000, 3'b000, 0,  0, 0, 12}; // right: col 3 -> 0
      tbl[5]  = '{6'b000010, 3'b000, 0,  0, 0, 15}; // down: row 3 -> 0
      tbl[6]  = '{6'b000010, 3'b000, 0,  0, 0, 14}; // down: row 1
      tbl[7]  = '{6'b010000, 3'b001, 1, 14, 1, 14};
      tbl[8]  = '{6'b001000, 3'b000, 0,  0, 0, 10}; // col 1
      tbl[9]  = '{6'b010000, 3'b111, 1, 10, 7, 10};
      tbl[10] = '{6'b000110, 3'b000, 0,  0, 0, 13}; // left+down together
      tbl[11] = '{6'b000011, 3'b000, 0,  0, 0, 13}; // up+down cancel
      tbl[12] = '{6'b001000, 3'b000, 0,  0, 0,  9}; // col 1

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_cursor", cursor, 15);
      rst = 1'b0;

      // Table-driven single presses
      for (int i = 0; i < 13; i++) begin
         w0 = wr_cnt;
         color_sel = tbl[i].color;
         press(tbl[i].mask, 10);
         check($sformatf("v%0d_writes", i), wr_cnt - w0, tbl[i].exp_wr);
         if (tbl[i].exp_wr == 1 && wr_cnt - w0 == 1) begin
            check($sformatf("v%0d_addr", i), addr_log[w0], tbl[i].exp_addr);
            check($sformatf("v%0d_data", i), data_log[w0], tbl[i].exp_data);
         end
         check($sformatf("v%0d_cursor", i), cursor, tbl[i].exp_cur);
      end

      // Clear sweep with a paint press arriving mid-sweep
      color_sel = 3'b101;
      w0 = wr_cnt;
      b0 = busy_cnt;
      @(posedge clk); #1;
      btn_clear = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) begin
            found = 1'b1;
            break;
         end
      end
      check("clr_busy_seen", found, 1);
      @(posedge clk); #1;
      btn_paint = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      btn_paint = 1'b0;
      btn_clear = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("clr_writes", wr_cnt - w0, 16);
      check("clr_busy_cycles", busy_cnt - b0, 16);
      bad = 0;
      for (int k = 0; k < 16; k++)
         if (addr_log[w0+k] != 4'(k) || data_log[w0+k] != 3'b000) bad++;
      check("clr_addr_data_bad", bad, 0);
      check("clr_busy_after", busy, 0);

      // Clear and paint debounced together: clear only
      w0 = wr_cnt;
      b0 = busy_cnt;
      press(6'b110000, 10);
      repeat (30) @(posedge clk);
      #1;
      check("both_writes", wr_cnt - w0, 16);
      check("both_busy_cycles", busy_cnt - b0, 16);
      bad = 0;
      for (int k = 0; k < 16; k++)
         if (addr_log[w0+k] != 4'(k) || data_log[w0+k] != 3'b000) bad++;
      check("both_seq_bad", bad, 0);
      check("both_cursor", cursor, 9);

      // Bouncing paint button: toggles every 2 cycles, then settles high
      color_sel = 3'b011;
      w0 = wr_cnt;
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         btn_paint = (k % 2 == 0);
         repeat (2) @(posedge clk);
         #1;
      end
      btn_paint = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      btn_paint = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check("bounce_writes", wr_cnt - w0, 1);
      check("bounce_addr", addr_log[w0], 9);
      check("bounce_data", data_log[w0], 3);

      // Reset in the middle of a clear sweep, at address 5
      w0 = wr_cnt;
      @(posedge clk); #1;
      btn_clear = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (wr_en && wr_addr == 4'd5) begin
            found = 1'b1;
            break;
         end
      end
      check("abort_addr5_seen", found, 1);
      rst = 1'b1;
      btn_clear = 1'b0;
      @(posedge clk); #1;
      check("abort_wr_en", wr_en, 0);
      check("abort_busy", busy, 0);
      check("abort_cursor", cursor, 15);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      w1 = wr_cnt;
      check("abort_writes_done", w1 - w0, 6);
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_more_writes", wr_cnt - w1, 0);

      // Paint held through reset release: one paint after debounce
      color_sel = 3'b110;
      rst = 1'b1;
      btn_paint = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      w0 = wr_cnt;
      repeat (12) @(posedge clk);
      #1;
      btn_paint = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check("held_rst_writes", wr_cnt - w0, 1);
      check("held_rst_addr", addr_log[w0], 15);
      check("held_rst_data", data_log[w0], 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
